// File: rtl/vpu_writeback.sv
// VPU result writeback: buffers two skewed lanes, pairs them into UB rows, writes rows with backpressure.
// Optional overflow detection is built when VPU_WB_OVF_EN is defined; otherwise err_ovf is tied low.
module vpu_writeback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_rows,
    input  logic [DATA_W-1:0]     lane1_data,
    input  logic                  lane1_valid,
    input  logic [DATA_W-1:0]     lane2_data,
    input  logic                  lane2_valid,
    output logic                  ub_wr_en,
    output logic [ADDR_W-1:0]     ub_wr_addr,
    output logic [2*DATA_W-1:0]   ub_wr_data,
    input  logic                  ub_wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [DATA_W-1:0]   mem1_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem2_r [FIFO_DEPTH];
    logic [PTR_W:0]      wr1_r, rd1_r, wr2_r, rd2_r;

    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   num_rows_r;
    logic [ADDR_W-1:0]   row_idx_r;
    logic [ADDR_W-1:0]   acc_cnt_r;

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [2*DATA_W-1:0] wr_data_r;
    logic                busy_r;
    logic                done_r;

    logic run_s, start_acc_s;
    logic empty1_s, empty2_s, full1_s, full2_s;
    logic push1_s, push2_s;
    logic row_ok_s, accept_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic logic fifo_full(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
        return (wr[PTR_W] != rd[PTR_W]) && (wr[PTR_W-1:0] == rd[PTR_W-1:0]);
    endfunction

    function automatic logic fifo_empty(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
        return (wr == rd);
    endfunction

    assign run_s       = (state_r == ST_RUN);
    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign empty1_s    = fifo_empty(wr1_r, rd1_r);
    assign empty2_s    = fifo_empty(wr2_r, rd2_r);
    assign full1_s     = fifo_full(wr1_r, rd1_r);
    assign full2_s     = fifo_full(wr2_r, rd2_r);
    assign push1_s     = run_s && lane1_valid && !full1_s;
    assign push2_s     = run_s && lane2_valid && !full2_s;
    assign accept_s    = wr_en_r && ub_wr_ready;
    assign row_ok_s    = run_s && !empty1_s && !empty2_s && (row_idx_r < num_rows_r)
                         && (!wr_en_r || ub_wr_ready);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; RUN ends on the acceptance of the last programmed row.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_rows != {ADDR_W{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && ((acc_cnt_r + ADDR_W'(1)) == num_rows_r)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO storage; data cells only change on a successful push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem1_r[i] <= {DATA_W{1'b0}};
                mem2_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push1_s) begin
                mem1_r[wr1_r[PTR_W-1:0]] <= lane1_data;
            end
            if (push2_s) begin
                mem2_r[wr2_r[PTR_W-1:0]] <= lane2_data;
            end
        end
    end

    // FIFO pointers; an accepted start flushes any leftover words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr1_r <= {(PTR_W+1){1'b0}};
            rd1_r <= {(PTR_W+1){1'b0}};
            wr2_r <= {(PTR_W+1){1'b0}};
            rd2_r <= {(PTR_W+1){1'b0}};
        end else if (start_acc_s) begin
            wr1_r <= {(PTR_W+1){1'b0}};
            rd1_r <= {(PTR_W+1){1'b0}};
            wr2_r <= {(PTR_W+1){1'b0}};
            rd2_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push1_s) begin
                wr1_r <= wr1_r + (PTR_W+1)'(1);
            end
            if (push2_s) begin
                wr2_r <= wr2_r + (PTR_W+1)'(1);
            end
            if (row_ok_s) begin
                rd1_r <= rd1_r + (PTR_W+1)'(1);
                rd2_r <= rd2_r + (PTR_W+1)'(1);
            end
        end
    end

    // Transfer parameters and row/acceptance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r     <= {ADDR_W{1'b0}};
            num_rows_r <= {ADDR_W{1'b0}};
            row_idx_r  <= {ADDR_W{1'b0}};
            acc_cnt_r  <= {ADDR_W{1'b0}};
        end else if (start_acc_s) begin
            base_r     <= base_addr;
            num_rows_r <= num_rows;
            row_idx_r  <= {ADDR_W{1'b0}};
            acc_cnt_r  <= {ADDR_W{1'b0}};
        end else begin
            if (row_ok_s) begin
                row_idx_r <= row_idx_r + ADDR_W'(1);
            end
            if (accept_s) begin
                acc_cnt_r <= acc_cnt_r + ADDR_W'(1);
            end
        end
    end

    // Output row register: loads a new row, clears on acceptance, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {(2*DATA_W){1'b0}};
        end else if (row_ok_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= base_r + row_idx_r;
            wr_data_r <= {mem2_r[rd2_r[PTR_W-1:0]], mem1_r[rd1_r[PTR_W-1:0]]};
        end else if (accept_s) begin
            wr_en_r   <= 1'b0;
        end else begin
            wr_en_r   <= wr_en_r;
        end
    end

    // Status outputs track the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

`ifdef VPU_WB_OVF_EN
    logic err_ovf_r;
    logic ovf_s;

    assign ovf_s = run_s && ((lane1_valid && full1_s) || (lane2_valid && full2_s));

    // Sticky overflow flag, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf_r <= 1'b0;
        end else if (start_acc_s) begin
            err_ovf_r <= 1'b0;
        end else if (ovf_s) begin
            err_ovf_r <= 1'b1;
        end else begin
            err_ovf_r <= err_ovf_r;
        end
    end

    assign err_ovf = err_ovf_r;
`else
    assign err_ovf = 1'b0;
`endif

    assign ub_wr_en   = wr_en_r;
    assign ub_wr_addr = wr_addr_r;
    assign ub_wr_data = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_vpu_writeback.sv
// Self-checking bench for vpu_writeback: table of transfer vectors plus hand-written corner sequences.
module tb_vpu_writeback;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int FD = 4;
`ifdef VPU_WB_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic [DW-1:0] lane1_data = '0;
    logic          lane1_valid = 1'b0;
    logic [DW-1:0] lane2_data = '0;
    logic          lane2_valid = 1'b0;
    logic          ub_wr_en;
    logic [AW-1:0] ub_wr_addr;
    logic [2*DW-1:0] ub_wr_data;
    logic          ub_wr_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err_ovf;

    vpu_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .lane1_data(lane1_data), .lane1_valid(lane1_valid),
        .lane2_data(lane2_data), .lane2_valid(lane2_valid),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
        .ub_wr_ready(ub_wr_ready), .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        int            nrows;
        int            skew;
        int            stall_from;
        int            stall_len;
        logic [DW-1:0] off;
    } vec_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] data;
    } wr_t;

    wr_t  sb_q[$];
    wr_t  mon_exp;
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cnt = 0;
    bit   mon_en = 1'b0;
    bit   held_v = 1'b0;
    logic [AW-1:0]   held_a;
    logic [2*DW-1:0] held_d;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: each accepted write is checked against the scoreboard, stalled rows must hold.
    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else if (mon_en) begin
            if (held_v) begin
                n_cmp++;
                if (!(ub_wr_en === 1'b1 && ub_wr_addr === held_a && ub_wr_data === held_d)) begin
                    n_bad++;
                    $display("FAIL stall_hold: got en=%0b addr=%0h data=%0h, want en=1 addr=%0h data=%0h",
                             ub_wr_en, ub_wr_addr, ub_wr_data, held_a, held_d);
                end
            end
            held_v = ub_wr_en && !ub_wr_ready;
            held_a = ub_wr_addr;
            held_d = ub_wr_data;
            if (ub_wr_en && ub_wr_ready) begin
                wr_cnt++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL write_unexpected: got addr=%0h data=%0h, want no write", ub_wr_addr, ub_wr_data);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (ub_wr_addr !== mon_exp.addr || ub_wr_data !== mon_exp.data) begin
                        n_bad++;
                        $display("FAIL write: got addr=%0h data=%0h, want addr=%0h data=%0h",
                                 ub_wr_addr, ub_wr_data, mon_exp.addr, mon_exp.data);
                    end
                end
            end
        end
    end

    // Drive both lanes for stream cycle c; the row completed by lane 2 is pushed as an expectation.
    task automatic drive_lanes(input int c, input vec_t v);
        int r;
        wr_t e;
        r = c - v.skew;
        lane1_valid = (c < v.nrows);
        lane1_data  = v.off + DW'(c + 1);
        lane2_valid = (r >= 0) && (r < v.nrows);
        lane2_data  = v.off + 16'h0100 + DW'(r + 1);
        if (lane2_valid) begin
            e.addr = v.base + AW'(r);
            e.data = {lane2_data, v.off + DW'(r + 1)};
            sb_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        start     = 1'b1;
        base_addr = b;
        num_rows  = n;
        tick();
        start = 1'b0;
    endtask

    // Run the stream of v until done, then check pulse count, row count and scoreboard drain.
    task automatic xfer_loop(input vec_t v, input int exp_rows, input string tag);
        int done_seen;
        int done_wr;
        int post;
        done_seen = 0;
        done_wr   = -1;
        post      = 0;
        for (int c = 0; c < 80; c++) begin
            drive_lanes(c, v);
            ub_wr_ready = !(c >= v.stall_from && c < v.stall_from + v.stall_len);
            @(negedge clk);
            if (done) begin
                done_seen++;
                done_wr = wr_cnt;
            end
            if (done_seen > 0) begin
                post++;
            end
            tick();
            if (post > 2) break;
        end
        lane1_valid = 1'b0;
        lane2_valid = 1'b0;
        ub_wr_ready = 1'b1;
        chk({tag, "_done_pulses"}, done_seen, 1);
        chk({tag, "_rows_at_done"}, done_wr, exp_rows);
        chk({tag, "_sb_drained"}, sb_q.size(), 0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        wr_cnt = 0;
        do_start(v.base, AW'(v.nrows));
        chk({tag, "_busy_run"}, busy, 1'b1);
        chk({tag, "_ovf_clear"}, err_ovf, 1'b0);
        xfer_loop(v, v.nrows, tag);
    endtask

    initial begin
        vec_t v;
        wr_t  e;
        bit   hit;
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        wr_t  e;
        bit   hit;
        vecs[0] = '{8'h10, 3, 1, 0, 0, 16'h0000};  // basic skewed stream
        vecs[1] = '{8'h10, 3, 1, 2, 4, 16'h0000};  // backpressure cycles 2-5
        vecs[2] = '{8'hFE, 3, 1, 0, 0, 16'h0020};  // address wrap
        vecs[3] = '{8'h20, 4, 0, 0, 0, 16'h0040};  // zero skew
        vecs[4] = '{8'h30, 4, 3, 0, 0, 16'h0060};  // skew fills lane 1 FIFO
        vecs[5] = '{8'h40, 5, 2, 3, 3, 16'h0080};  // skew plus stall

        #3;
        chk("rst_en", ub_wr_en, 1'b0);
        chk("rst_addr", ub_wr_addr, 8'h00);
        chk("rst_data", ub_wr_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", err_ovf, 1'b0);
        tick();
        rst    = 1'b1;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Overflow: five lane 1 words into a four-deep FIFO, then a stray start, then lane 2.
        wr_cnt = 0;
        do_start(8'h50, 8'd4);
        for (int c = 0; c < 5; c++) begin
            lane1_valid = 1'b1;
            lane1_data  = DW'(c + 1);
            tick();
        end
        lane1_valid = 1'b0;
        chk("ovf_flag", err_ovf, OVF_EN);
        for (int r = 0; r < 4; r++) begin
            start       = (r == 0);
            base_addr   = 8'h99;
            num_rows    = 8'd0;
            lane2_valid = 1'b1;
            lane2_data  = DW'(11 + r);
            e.addr = 8'h50 + AW'(r);
            e.data = {DW'(11 + r), DW'(r + 1)};
            sb_q.push_back(e);
            tick();
        end
        start       = 1'b0;
        lane2_valid = 1'b0;
        v = '{8'h00, 0, 0, 0, 0, 16'h0000};
        xfer_loop(v, 4, "ovf");
        chk("ovf_sticky", err_ovf, OVF_EN);

        // Zero rows: done the cycle after start, no writes.
        wr_cnt = 0;
        do_start(8'h70, 8'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b1);
        chk("zero_ovf_clear", err_ovf, 1'b0);
        tick();
        chk("zero_done_low", done, 1'b0);
        chk("zero_busy_low", busy, 1'b0);
        tick();
        chk("zero_no_writes", wr_cnt, 0);

        // Reset mid-run after the first row is accepted.
        wr_cnt = 0;
        v = '{8'h60, 3, 1, 0, 0, 16'h0300};
        do_start(v.base, 8'd3);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            drive_lanes(c, v);
            tick();
            if (wr_cnt >= 1) begin
                hit = 1'b1;
            end
        end
        chk("rstmid_reached", hit, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstmid_en", ub_wr_en, 1'b0);
        chk("rstmid_addr", ub_wr_addr, 8'h00);
        chk("rstmid_data", ub_wr_data, 32'h0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_rows", wr_cnt, 1);
        sb_q.delete();
        lane1_valid = 1'b0;
        lane2_valid = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid_no_done", done, 1'b0);
            tick();
        end
        run_vec(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
